// File: rtl/popcnt_arbiter.sv
// Arbitrated 64-bit popcount engine: grants one requester, counts its word, returns count + ID.
// Define POPCNT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | arbitrate, drive req_ready to the winner, latch word on handshake
// LOAD  | ones-counter evaluates op_reg, result registered into rsp_*
// COUNT | raise rsp_valid
// RESP  | hold response until rsp_ready
module popcnt_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 64,
   parameter int CW   = $clog2(DW + 1),
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [CW-1:0]      rsp_count,
   output logic               rsp_onehot,
   output logic               rsp_onecold,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, LOAD, COUNT, RESP} state_t;

   state_t          state;
   logic [DW-1:0]   op_reg;
   logic [IDW-1:0]  id_reg;
   logic [IDW-1:0]  win;
   logic            found;
   logic [NREQ-1:0] grant_oh;
   logic [CW-1:0]   cnt;

`ifdef POPCNT_ARB_RR_EN
   logic [IDW-1:0]  ptr;
`endif

   always_comb begin
      found = 1'b0;
      win   = '0;
`ifdef POPCNT_ARB_RR_EN
      // search begins one past the last winner
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr) + k) % NREQ);
         end
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = IDW'(i);
         end
      end
`endif
      grant_oh = found ? (NREQ'(1) << win) : '0;
   end

   assign req_ready = (state == IDLE) ? grant_oh : '0;
   assign busy      = (state != IDLE);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DW; i++) begin
         cnt = cnt + CW'(op_reg[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_reg      <= '0;
         id_reg      <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_count   <= '0;
         rsp_onehot  <= 1'b0;
         rsp_onecold <= 1'b0;
`ifdef POPCNT_ARB_RR_EN
         ptr         <= IDW'(NREQ - 1);
`endif
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  op_reg <= req_data[int'(win)*DW +: DW];
                  id_reg <= win;
`ifdef POPCNT_ARB_RR_EN
                  ptr    <= win;
`endif
                  state  <= LOAD;
               end
            end
            LOAD: begin
               rsp_count   <= cnt;
               rsp_onehot  <= (cnt == CW'(1));
               rsp_onecold <= (cnt == CW'(DW - 1));
               rsp_id      <= id_reg;
               state       <= COUNT;
            end
            COUNT: begin
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
